// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial pattern transmitter.
//   state_t          FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   DEFAULT_PATTERN  pattern sent when the top-level PATTERN is not overridden
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_piso.sv
// pattern_piso: loadable parallel-in serial-out shift register, MSB first.
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the register
//   clr       synchronous clear (used on abort)
//   load      load PATTERN into the register
//   shift_en  shift left by one, zero fill
//   msb       current serial bit (register MSB)
// Priority: rst/clr > load > shift_en.
module pattern_piso #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic shift_en,
    output logic msb
);

    logic [PAT_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= PATTERN;
        end else if (shift_en) begin
            sreg <= {sreg[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = sreg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Sends PATTERN MSB-first rep_cnt times, with gap_len zero bits between repeats.
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    launch request, sampled only in IDLE
//   rep_cnt  number of repeats, latched on accepted start
//   gap_len  zero bits between repeats, latched on accepted start
//   bit_en   advance strobe; current bit is held until bit_en=1
//   abort    cancel transfer (SHIFT/GAP only)
//   x        serial data (registered)
//   x_valid  x carries a pattern or gap bit
//   busy     transfer in progress
//   done     one-cycle completion pulse
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [CNT_W-1:0] gap_len,
    input  logic             bit_en,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

    state_t           state;
    logic [BIT_W-1:0] bit_idx;
    logic [CNT_W-1:0] rem_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_len_q;

    logic adv;
    logic last_bit;
    logic more;
    logic launch;
    logic reload;
    logic piso_load;
    logic piso_shift;
    logic piso_clr;

    always_comb begin
        adv        = bit_en && !abort;
        last_bit   = (state == SHIFT) && adv && (bit_idx == LAST_IDX);
        more       = (rem_cnt != CNT_W'(1));
        launch     = (state == IDLE) && start && (rep_cnt != '0);
        reload     = (last_bit && more && (gap_len_q == '0)) ||
                     ((state == GAP) && adv && (gap_cnt == CNT_W'(1)));
        piso_load  = launch || reload;
        // Shifting out the last bit leaves the register zero, so x drops to 0
        // for GAP and DONE without a separate clear.
        piso_shift = (state == SHIFT) && adv && !reload;
        piso_clr   = abort && ((state == SHIFT) || (state == GAP));
    end

    pattern_piso #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .clr      (piso_clr),
        .load     (piso_load),
        .shift_en (piso_shift),
        .msb      (x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            rem_cnt   <= '0;
            gap_cnt   <= '0;
            gap_len_q <= '0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem_cnt   <= rep_cnt;
                        gap_len_q <= gap_len;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
                        if (rep_cnt != '0) begin
                            state   <= SHIFT;
                            x_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state   <= IDLE;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else if (adv) begin
                        if (bit_idx != LAST_IDX) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            bit_idx <= '0;
                            rem_cnt <= rem_cnt - 1'b1;
                            if (!more) begin
                                state   <= DONE;
                                x_valid <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else if (gap_len_q != '0) begin
                                state   <= GAP;
                                gap_cnt <= gap_len_q;
                            end
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state   <= IDLE;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else if (adv) begin
                        if (gap_cnt == CNT_W'(1)) begin
                            state <= SHIFT;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    // busy still set means we arrived straight from IDLE with
                    // rep_cnt==0: spend one more cycle here to emit done.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] gap_len;
    logic             bit_en;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    logic [3:0] pat_v = 4'b1011;

    always #5 clk = ~clk;

    seq_pattern_tx #(
        .PAT_W   (PAT_W),
        .PATTERN (4'b1011),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rep_cnt (rep_cnt),
        .gap_len (gap_len),
        .bit_en  (bit_en),
        .abort   (abort),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    int   total = 0;
    int   bad   = 0;
    bit   exp_q[$];
    int   valid_cnt = 0;
    int   done_cnt  = 0;
    int   match_cnt = 0;
    int   nbits     = 0;
    logic [3:0] win = '0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: a bit is emitted when it is valid and retired by bit_en.
    always @(negedge clk) begin
        if (x_valid) valid_cnt++;
        if (done) done_cnt++;
        if (x_valid && bit_en) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 1, 0);
            end else begin
                check("sb_bit", int'(x), int'(exp_q.pop_front()));
                win = {win[2:0], x};
                nbits++;
                if (nbits >= 4 && win == pat_v) match_cnt++;
            end
        end
    end

    task automatic clr_stats();
        valid_cnt = 0;
        done_cnt  = 0;
        match_cnt = 0;
        nbits     = 0;
        win       = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_start(input int rc, input int gl);
        start   = 1'b1;
        rep_cnt = CNT_W'(rc);
        gap_len = CNT_W'(gl);
        for (int r = 0; r < rc; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat_v[b]);
            if (r < rc - 1) for (int g = 0; g < gl; g++) exp_q.push_back(1'b0);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            @(negedge clk);
            n++;
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; bit_en = 1'b1; abort = 1'b0;
        rep_cnt = '0; gap_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_valid", int'(x_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        cycle();
        rst = 1'b0;
        cycle();

        // 1: single pattern, full rate
        clr_stats();
        do_start(1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            @(negedge clk);
            check("t1_x", int'(x), int'(pat_v[3-i]));
            check("t1_valid", int'(x_valid), 1);
            check("t1_busy", int'(busy), 1);
        end
        cycle();
        @(negedge clk);
        check("t1_done", int'(done), 1);
        check("t1_busy_end", int'(busy), 0);
        check("t1_valid_end", int'(x_valid), 0);
        cycle();
        @(negedge clk);
        check("t1_done_off", int'(done), 0);

        // 2: three back-to-back repeats
        clr_stats();
        do_start(3, 0);
        wait_done(n);
        check("t2_done_at", n, 13);
        check("t2_valid", valid_cnt, 12);
        check("t2_matches", match_cnt, 3);
        cycle();
        @(negedge clk);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_sb_left", exp_q.size(), 0);

        // 3: two repeats with a 2-bit gap, start pulsed mid-transfer
        clr_stats();
        do_start(2, 2);
        repeat (3) cycle();
        start   = 1'b1;
        rep_cnt = 8'd5;
        wait_done(n);
        check("t3_done_at", n + 3, 11);
        check("t3_valid", valid_cnt, 10);
        repeat (5) cycle();
        @(negedge clk);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_busy_end", int'(busy), 0);
        check("t3_sb_left", exp_q.size(), 0);

        // 4: bit_en every 3rd cycle
        clr_stats();
        bit_en = 1'b0;
        do_start(1, 0);
        for (int k = 1; k <= 13; k++) begin
            cycle();
            bit_en = (k % 3 == 0);
            @(negedge clk);
            if (k <= 12) begin
                check("t4_x", int'(x), int'(pat_v[3-(k-1)/3]));
                check("t4_valid", int'(x_valid), 1);
                check("t4_done_early", int'(done), 0);
            end else begin
                check("t4_done", int'(done), 1);
            end
        end
        bit_en = 1'b1;
        cycle();
        check("t4_sb_left", exp_q.size(), 0);

        // 5: abort, then rst, after the 2nd bit; fresh start afterwards
        for (int v = 0; v < 2; v++) begin
            clr_stats();
            do_start(2, 0);
            cycle(); @(negedge clk);
            cycle(); @(negedge clk);
            cycle();
            if (v == 0) abort = 1'b1; else rst = 1'b1;
            @(negedge clk);
            cycle();
            abort = 1'b0;
            rst   = 1'b0;
            @(negedge clk);
            check("t5_x", int'(x), 0);
            check("t5_valid", int'(x_valid), 0);
            check("t5_busy", int'(busy), 0);
            repeat (6) cycle();
            @(negedge clk);
            check("t5_no_done", done_cnt, 0);
            exp_q.delete();
            clr_stats();
            do_start(1, 0);
            wait_done(n);
            check("t5_restart_at", n, 5);
            check("t5_restart_sb", exp_q.size(), 0);
            cycle();
        end

        // 6: rep_cnt = 0; start in the DONE cycle is ignored
        clr_stats();
        do_start(0, 0);
        cycle();
        @(negedge clk);
        check("t6_busy", int'(busy), 1);
        check("t6_done_early", int'(done), 0);
        cycle();
        start   = 1'b1;
        rep_cnt = 8'd1;
        @(negedge clk);
        check("t6_done", int'(done), 1);
        check("t6_busy_off", int'(busy), 0);
        cycle();
        @(negedge clk);
        check("t6_busy_ign", int'(busy), 0);
        check("t6_done_off", int'(done), 0);
        repeat (3) cycle();
        @(negedge clk);
        check("t6_valid", valid_cnt, 0);
        check("t6_sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
